// File: rtl/spi_reg_pkg.sv
// Shared FSM state type and frame-layout constants for the SPI register responder.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INSTR,
      WDATA,
      RDATA,
      DONE
   } state_t;

   localparam int INSTR_BITS = 16;
   localparam int ADDR_BITS  = 13;
   localparam int RW_BIT     = 15;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer plus history flop; reports rising and falling edges of the
// synchronized level. rst_val sets the idle level the chain resets to.
module spi_edge_sync #(
   parameter int   sync_n  = 2,
   parameter logic rst_val = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [sync_n-1:0] sync_q;
   logic              hist_q;
   logic              level;

   // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {sync_n{rst_val}};
         hist_q <= rst_val;
      end else begin
         sync_q <= {sync_q[sync_n-2:0], din};
         hist_q <= sync_q[sync_n-1];
      end
   end

   assign level = sync_q[sync_n-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_responder.sv
// 3-wire SPI register-file target: oversampled CSB/SCLK/SDIO, 16-bit instruction, byte data.
// Define MULTIBYTE_STREAM_EN to continue frames byte after byte with a decrementing address.
module spi_reg_responder
   import spi_reg_pkg::*;
#(
   parameter int aw     = 5,
   parameter int sync_n = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          csb,
   input  logic          sclk,
   input  logic          sdio_in,
   output logic          sdio_out,
   output logic          sdio_oe,
   input  logic [aw-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          wr_strobe,
   output logic [aw-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          busy,
   output logic          frame_err
);

`ifdef MULTIBYTE_STREAM_EN
   localparam bit stream_en = 1'b1;
`else
   localparam bit stream_en = 1'b0;
`endif

   logic sclk_rise, sclk_fall, csb_rise, csb_fall;
   logic [sync_n:0] sdio_sync_q;
   logic            sdio_s;

   state_t                 state_q, state_d;
   logic [3:0]             bit_cnt_q;
   logic [INSTR_BITS-2:0]  instr_q;
   logic [INSTR_BITS-1:0]  instr_next;
   logic [ADDR_BITS-1:0]   addr_q, ld_addr;
   logic [7:0]             data_sr_q, wr_byte, ld_byte;
   logic [7:0]             mem_q [2**aw];
   logic                   addr_ok;

   logic start, instr_shift, wr_shift, commit, rd_present, rd_count, rd_end, err_set;

   spi_edge_sync #(.sync_n(sync_n), .rst_val(1'b0)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_edge_sync #(.sync_n(sync_n), .rst_val(1'b1)) u_csb_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (csb),
      .rise (csb_rise),
      .fall (csb_fall)
   );

   // Data uses the history stage so it is never younger than the detected sclk edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sdio_sync_q <= '0;
      else     sdio_sync_q <= {sdio_sync_q[sync_n-1:0], sdio_in};
   end
   assign sdio_s = sdio_sync_q[sync_n];

   assign instr_next = {instr_q, sdio_s};
   assign wr_byte    = {data_sr_q[6:0], sdio_s};
   assign addr_ok    = (addr_q >> aw) == '0;
   assign ld_addr    = (state_q == INSTR) ? instr_next[ADDR_BITS-1:0] : addr_q - ADDR_BITS'(1);
   assign ld_byte    = ((ld_addr >> aw) == '0) ? mem_q[ld_addr[aw-1:0]] : 8'h00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default up front so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      start       = 1'b0;
      instr_shift = 1'b0;
      wr_shift    = 1'b0;
      commit      = 1'b0;
      rd_present  = 1'b0;
      rd_count    = 1'b0;
      rd_end      = 1'b0;
      err_set     = 1'b0;
      if (csb_rise) begin
         state_d = IDLE;
         err_set = (state_q inside {INSTR, WDATA, RDATA}) && (bit_cnt_q != '0);
      end else begin
         case (state_q)
            IDLE: begin
               if (csb_fall) begin
                  state_d = INSTR;
                  start   = 1'b1;
               end
            end
            INSTR: begin
               if (sclk_rise) begin
                  instr_shift = 1'b1;
                  if (bit_cnt_q == 4'(INSTR_BITS - 1))
                     state_d = instr_next[RW_BIT] ? RDATA : WDATA;
               end
            end
            WDATA: begin
               if (sclk_rise) begin
                  wr_shift = 1'b1;
                  if (bit_cnt_q == 4'd7) begin
                     commit  = 1'b1;
                     state_d = stream_en ? WDATA : DONE;
                  end
               end
            end
            RDATA: begin
               if (sclk_rise) begin
                  rd_count = 1'b1;
                  if (bit_cnt_q == 4'd7) begin
                     rd_end  = 1'b1;
                     state_d = stream_en ? RDATA : DONE;
                  end
               end else if (sclk_fall) begin
                  rd_present = 1'b1;
               end
            end
            DONE:    ;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: the register file is built from resettable flops because rst must clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q <= '0;
         instr_q   <= '0;
         addr_q    <= '0;
         data_sr_q <= '0;
         sdio_oe   <= 1'b0;
         sdio_out  <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < 2**aw; i++) mem_q[i] <= 8'h00;
      end else begin
         wr_strobe <= 1'b0;
         if (csb_fall)      busy <= 1'b1;
         else if (csb_rise) busy <= 1'b0;
         if (csb_rise) begin
            sdio_oe  <= 1'b0;
            sdio_out <= 1'b0;
         end
         if (err_set) frame_err <= 1'b1;
         if (start) begin
            bit_cnt_q <= '0;
            frame_err <= 1'b0;
         end
         // The 4-bit counter wraps 15 -> 0 exactly as the instruction completes.
         if (instr_shift) begin
            instr_q   <= instr_next[INSTR_BITS-2:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(INSTR_BITS - 1)) begin
               addr_q    <= instr_next[ADDR_BITS-1:0];
               data_sr_q <= ld_byte;
            end
         end
         if (wr_shift) begin
            data_sr_q <= wr_byte;
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         if (commit) begin
            bit_cnt_q <= '0;
            if (addr_ok) begin
               mem_q[addr_q[aw-1:0]] <= wr_byte;
               wr_strobe             <= 1'b1;
               wr_addr               <= addr_q[aw-1:0];
               wr_data               <= wr_byte;
            end
            if (stream_en) addr_q <= addr_q - ADDR_BITS'(1);
         end
         if (rd_present) begin
            sdio_oe   <= 1'b1;
            sdio_out  <= data_sr_q[7];
            data_sr_q <= {data_sr_q[6:0], 1'b0};
         end
         if (rd_count) bit_cnt_q <= bit_cnt_q + 4'd1;
         if (rd_end) begin
            bit_cnt_q <= '0;
            if (stream_en) begin
               addr_q    <= ld_addr;
               data_sr_q <= ld_byte;
            end else begin
               sdio_oe  <= 1'b0;
               sdio_out <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= 8'h00;
      else     rd_data <= mem_q[rd_addr];
   end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: directed frames, randomized frames and a
// byte-array reference model of the register file. Honours MULTIBYTE_STREAM_EN.
module tb_spi_reg_responder;

   localparam int AW   = 5;
   localparam int HALF = 6;
`ifdef MULTIBYTE_STREAM_EN
   localparam bit STREAM = 1'b1;
`else
   localparam bit STREAM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, csb, sclk, sdio_in;
   logic          sdio_out, sdio_oe, wr_strobe, busy, frame_err;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [7:0]    rd_data, wr_data;

   always #5 clk = ~clk;

   spi_reg_responder #(.aw(AW), .sync_n(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .csb       (csb),
      .sclk      (sclk),
      .sdio_in   (sdio_in),
      .sdio_out  (sdio_out),
      .sdio_oe   (sdio_oe),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .frame_err (frame_err)
   );

   int               vectors     = 0;
   int               miscompares = 0;
   logic [7:0]       model_mem [32];
   logic [7:0]       wbyte [3];
   logic [7:0]       rbyte [3];
   int               oe_bad;
   logic [AW+7:0]    exp_q [$];
   logic [AW+7:0]    got_q [$];
   logic             strobe_prev = 1'b0;
   logic [7:0]       rd_after_strobe;

   always @(negedge clk) begin
      if (strobe_prev) rd_after_strobe = rd_data;
      strobe_prev = wr_strobe;
      if (wr_strobe) got_q.push_back({wr_addr, wr_data});
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: bench did not finish within its cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bit-level SPI master: tot bits (instruction first), sampling sdio_out just before each rise.
   task automatic spi_xfer(input logic [15:0] instr, input int tot);
      bit exp_oe;
      oe_bad = 0;
      for (int k = 0; k < 3; k++) rbyte[k] = 8'h00;
      csb = 1'b0;
      wait_clk(6);
      for (int i = 0; i < tot; i++) begin
         if (i < 16)         sdio_in = instr[15-i];
         else if (instr[15]) sdio_in = 1'b0;
         else                sdio_in = wbyte[(i-16)/8][7-((i-16)%8)];
         wait_clk(HALF);
         exp_oe = instr[15] && (i >= 16) && (STREAM || i < 24);
         if (sdio_oe !== exp_oe) oe_bad++;
         if (i >= 16) rbyte[(i-16)/8][7-((i-16)%8)] = sdio_out;
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
      wait_clk(HALF);
      csb = 1'b1;
      wait_clk(4);
      sdio_in = 1'b0;
   endtask

   // Predicts the frame's effect from the frame rules, runs it, and compares everything.
   task automatic run_frame(input string tag, input logic [15:0] instr, input int tot);
      logic [12:0] base, a;
      int          nfull, nb;
      bit          is_read, exp_err;
      logic [7:0]  exp_rd [3];
      is_read = instr[15];
      base    = instr[12:0];
      nfull   = (tot >= 16) ? (tot - 16) / 8 : 0;
      nb      = STREAM ? nfull : ((nfull > 0) ? 1 : 0);
      if (tot > 0 && tot < 16) exp_err = 1'b1;
      else if (tot > 16)       exp_err = STREAM ? ((tot - 16) % 8 != 0) : ((tot - 16) < 8);
      else                     exp_err = 1'b0;
      for (int k = 0; k < 3; k++) exp_rd[k] = 8'h00;
      for (int k = 0; k < nb; k++) begin
         a = base - 13'(k);
         if (is_read) begin
            exp_rd[k] = (a < 13'd32) ? model_mem[a[4:0]] : 8'h00;
         end else if (a < 13'd32) begin
            model_mem[a[4:0]] = wbyte[k];
            exp_q.push_back({a[4:0], wbyte[k]});
         end
      end
      got_q.delete();
      spi_xfer(instr, tot);
      check({tag, " oe window"}, oe_bad, 0);
      check({tag, " frame_err"}, frame_err, exp_err);
      check({tag, " busy idle"}, busy, 0);
      check({tag, " oe after csb"}, sdio_oe, 0);
      check({tag, " strobe count"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         check($sformatf("%s strobe %0d", tag, k), got_q[k], exp_q[k]);
      if (is_read)
         for (int k = 0; k < nb; k++)
            check($sformatf("%s read byte %0d", tag, k), rbyte[k], exp_rd[k]);
      exp_q.delete();
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 32; a++) begin
         rd_addr = AW'(a);
         wait_clk(2);
         check($sformatf("%s mem[%0d]", tag, a), rd_data, model_mem[a]);
      end
   endtask

   initial begin
      logic [15:0] ri;
      logic [12:0] ra;
      int          tot;

      for (int a = 0; a < 32; a++) model_mem[a] = 8'h00;
      rst = 1'b1; csb = 1'b1; sclk = 1'b0; sdio_in = 1'b0; rd_addr = '0;
      wait_clk(3);
      check("reset sdio_oe", sdio_oe, 0);
      check("reset sdio_out", sdio_out, 0);
      check("reset busy", busy, 0);
      check("reset frame_err", frame_err, 0);
      check("reset wr_strobe", wr_strobe, 0);
      check("reset rd_data", rd_data, 0);
      rst = 1'b0;
      wait_clk(4);
      check("idle busy", busy, 0);

      // Single write, then local readback including the cycle right after the strobe.
      rd_addr = 5'd3;
      rd_after_strobe = 'x;
      wbyte[0] = 8'hA5; wbyte[1] = 8'h00; wbyte[2] = 8'h00;
      run_frame("wr 0x0003", 16'h0003, 24);
      check("rd_data one cycle after strobe", rd_after_strobe, 8'hA5);
      check("rd_data at 3", rd_data, 8'hA5);

      run_frame("rd 0x8003", 16'h8003, 24);

      // Out-of-range address: dropped write, zero read, no aliasing onto address 0.
      wbyte[0] = 8'h5A;
      run_frame("wr 0x0040", 16'h0040, 24);
      run_frame("rd 0x8040", 16'h8040, 24);
      rd_addr = 5'd0;
      wait_clk(2);
      check("no alias mem[0]", rd_data, model_mem[0]);

      // Partial data byte and partial instruction, then a clean frame clears the error.
      wbyte[0] = 8'h3C;
      run_frame("partial wr 0x0002", 16'h0002, 20);
      rd_addr = 5'd2;
      wait_clk(2);
      check("mem[2] after partial", rd_data, model_mem[2]);
      run_frame("partial instr", 16'h8002, 8);
      wbyte[0] = 8'h77;
      run_frame("wr 0x0001", 16'h0001, 24);

      wbyte[0] = 8'h11; wbyte[1] = 8'h22; wbyte[2] = 8'h33;
      run_frame("3-byte wr 0x0005", 16'h0005, 40);
      run_frame("3-byte rd 0x8005", 16'h8005, 40);
      sweep("after directed");

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       ra = 13'($urandom_range(0, 31));
            1:       ra = 13'($urandom_range(32, 63));
            2:       ra = 13'($urandom_range(0, 2));
            default: ra = 13'($urandom);
         endcase
         ri = {1'($urandom), 2'($urandom), ra};
         for (int k = 0; k < 3; k++) wbyte[k] = 8'($urandom);
         case ($urandom_range(0, 5))
            0, 1, 2: tot = 24;
            3:       tot = 32;
            4:       tot = 40;
            default: tot = $urandom_range(1, 39);
         endcase
         run_frame($sformatf("rand %0d instr 0x%04h bits %0d", n, ri, tot), ri, tot);
      end
      sweep("after random");

      // Reset in the middle of a read data byte.
      ri = 16'h8005;
      csb = 1'b0;
      wait_clk(6);
      for (int i = 0; i < 19; i++) begin
         sdio_in = (i < 16) ? ri[15-i] : 1'b0;
         wait_clk(HALF);
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
      wait_clk(4);
      check("mid-read sdio_oe", sdio_oe, 1);
      check("mid-read busy", busy, 1);
      rst = 1'b1;
      #1;
      check("rst sdio_oe", sdio_oe, 0);
      check("rst busy", busy, 0);
      check("rst frame_err", frame_err, 0);
      csb = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      for (int a = 0; a < 32; a++) model_mem[a] = 8'h00;
      wait_clk(4);
      sweep("after rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- Synthesizable SPI register-file responder: the target end of the 3-wire SDIO protocol that llspi drives toward the digitizer ADCs (CSB, SCLK, bidirectional SDIO, 16-bit instruction then data bytes).
- Used as an on-chip loopback target and bench model for llspi and the digitizer config path.
- Oversamples SCLK and CSB in its own clock domain, decodes read and write frames, holds a byte-wide register file, and exposes a local read port and a write-notify strobe.

Parameters:
- aw, 5, register-file address width (2^aw bytes).
- sync_n, 2, synchronizer depth on csb/sclk/sdio_in (≥2).

Ports:
- clk  in  1  system clock; SCLK period must be ≥ 8 clk periods.
- rst  in  1  reset, asynchronous, active-high.
- csb  in  1  SPI chip select, active low.
- sclk  in  1  SPI clock, idle low.
- sdio_in  in  1  SDIO pad input.
- sdio_out  out  1  SDIO pad output data.
- sdio_oe  out  1  SDIO output enable (1 = responder drives).
- rd_addr  in  aw  local read address.
- rd_data  out  8  register contents at rd_addr, 1-cycle registered.
- wr_strobe  out  1  one-cycle pulse when an SPI write commits.
- wr_addr  out  aw  address of the committed write.
- wr_data  out  8  data of the committed write.
- busy  out  1  frame in progress (synchronized CSB low).
- frame_err  out  1  sticky; set on bad frame; cleared by rst or the next valid frame start.

Behaviour:
- Reset values: all outputs 0; register file all 0x00; state IDLE.
- Synchronization:
  - csb, sclk and sdio_in each pass through sync_n flops plus one history flop.
  - Rise and fall detection uses the synchronized sclk; all decoding happens on these detected edges.
- Frame format (MSB first):
  - Bit 15: R/W (1 = read).
  - Bits 14:13: W1:W0 (ignored).
  - Bits 12:0: address.
  - Then 8-bit data byte(s).
- States:
  - IDLE → INSTR on synchronized csb fall; bit counter cleared; frame_err cleared.
  - INSTR: shift sdio_in on each sclk rise. After the 16th rise, go to WDATA if R/W=0, else RDATA.
  - WDATA: shift on each sclk rise. On the 8th rise, write mem[addr] and pulse wr_strobe (with wr_addr/wr_data) on the clk cycle after the detected edge. Then go to DONE, or stay in WDATA under the optional feature.
  - RDATA:
    - On entry, load the shift register with mem[addr].
    - sdio_oe rises on the first sclk fall after instruction bit 0; sdio_out then presents the shift-register MSB.
    - Shift on each subsequent sclk fall.
    - After 8 bits, go to DONE, or reload under the optional feature.
  - DONE: ignore sclk until csb rises.
  - Any state → IDLE on synchronized csb rise; sdio_oe drops the same cycle.
- Address decode: addresses ≥ 2^aw are out of range.
  - Writes to them are dropped: no wr_strobe.
  - Reads from them return 0x00.
  - Upper address bits are never aliased.
- frame_err is set when csb rises with the bit counter not on a byte boundary after the instruction (0 < count < 16, or a partial data byte). A partial write byte is never committed.
- Simultaneous events:
  - An sclk edge in the same cycle as a csb rise is ignored.
  - A local rd_addr read of the location being written returns the new value one cycle after wr_strobe.
- rst mid-frame: immediate return to IDLE; sdio_oe=0; the register file clears.

Optional Feature:
- MULTIBYTE_STREAM_EN defined:
  - After each data byte the address decrements by 1 (13-bit wrap, 0x0000 → 0x1FFF) and the next byte continues in the same state.
  - Writes commit per byte, each with its own wr_strobe.
  - Reads reload the shift register per byte.
- Undefined: exactly one data byte per frame; further sclk edges are ignored until csb rises, and no frame_err is raised for them.

Decomposition:
- Package spi_reg_pkg:
  - State enum (IDLE, INSTR, WDATA, RDATA, DONE).
  - Constants INSTR_BITS=16, ADDR_BITS=13, RW_BIT=15.
- Sub-module spi_edge_sync: synchronizer plus edge detector, parameterized by sync_n, instanced for sclk and csb; sdio_in uses the plain sync path.

Test Plan:
- Write frame instr 0x0003, data 0xA5 → single wr_strobe, wr_addr=3, wr_data=0xA5; rd_addr=3 gives rd_data=0xA5.
- Read frame instr 0x8003 after the above → sdio_oe high only during the data byte; sampled bits on sclk rise = 1010_0101; sdio_oe=0 within one cycle of csb rise.
- Write to address 0x0040 with aw=5 → no wr_strobe, memory unchanged; read of 0x0040 returns 0x00.
- csb raised after 4 data bits of a write to addr 2 → frame_err=1, mem[2] unchanged. Next frame start clears frame_err.
- With MULTIBYTE_STREAM_EN: write instr 0x0005, data 0x11,0x22,0x33 → mem[5]=0x11, mem[4]=0x22, mem[3]=0x33 with three strobes. Without the macro: only mem[5]=0x11.
- Assert rst during an RDATA byte → sdio_oe=0 and busy=0 immediately; all registers read 0x00 afterward.
